// File: rtl/binary_to_octal_driver.sv
// Takes a binary code over valid/ready and drives its one-hot line for HOLD cycles,
// then drives all zeros for GAP cycles before the next code can be accepted.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | y=0, in_ready=1, waiting for in_valid
// S_DRIVE | one-hot line asserted, counting down HOLD cycles
// S_GAP   | y=0, counting down GAP cycles before returning to idle
module binary_to_octal_driver #(
    parameter int N    = 3,
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [N-1:0]      in_code,
    output logic              in_ready,
    output logic [2**N-1:0]   y,
    output logic              busy,
    output logic              done
);

    localparam int W      = 2**N;
    localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAX_C  = (MAX_HG > 1) ? MAX_HG : 1;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   y_q, y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    y_d     = W'(1) << in_code;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    y_d = '0;
                    // With no gap the idle cycle itself separates consecutive pulses.
                    if (GAP > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                y_d     = '0;
            end
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DRIVE) && (cnt_q == '0);
    assign y        = y_q;

endmodule

// File: tb/tb_binary_to_octal_driver.sv
// Bench for binary_to_octal_driver: a default instance (HOLD=4, GAP=1) and a corner
// instance (HOLD=1, GAP=0), both checked every cycle against a timeline model.
module tb_binary_to_octal_driver;

    logic       clk = 1'b0;
    logic       rst_s   [2];
    logic       valid_s [2];
    logic [2:0] code_s  [2];
    logic       ready_s [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [7:0] y_s     [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt0 = 0;

    // Model: cycles since acceptance (1..HOLD+GAP), or -1 when idle.
    int         since [2] = '{-1, -1};
    logic [2:0] mcode [2];

    always #5 clk = ~clk;

    binary_to_octal_driver #(.N(3), .HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .rst(rst_s[0]), .in_valid(valid_s[0]), .in_code(code_s[0]),
        .in_ready(ready_s[0]), .y(y_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    binary_to_octal_driver #(.N(3), .HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst(rst_s[1]), .in_valid(valid_s[1]), .in_code(code_s[1]),
        .in_ready(ready_s[1]), .y(y_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    function automatic int hold_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int gap_of(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_s[i]) begin
                since[i] = -1;
            end else if (since[i] < 0) begin
                if (valid_s[i]) begin
                    since[i] = 1;
                    mcode[i] = code_s[i];
                end
            end else begin
                since[i] = since[i] + 1;
                if (since[i] > hold_of(i) + gap_of(i)) since[i] = -1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] ey;
        logic       active;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            active = (since[i] >= 1) && (since[i] <= hold_of(i));
            ey     = active ? (8'd1 << mcode[i]) : 8'd0;
            check_val($sformatf("y[%0d]", i),     32'(y_s[i]),     32'(ey));
            check_val($sformatf("done[%0d]", i),  32'(done_s[i]),  32'(since[i] == hold_of(i)));
            check_val($sformatf("busy[%0d]", i),  32'(busy_s[i]),  32'(since[i] >= 1));
            check_val($sformatf("ready[%0d]", i), 32'(ready_s[i]), 32'(since[i] < 0));
        end
        done_cnt0 += int'(done_s[0]);
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] c);
        for (int i = 0; i < 2; i++) begin
            rst_s[i]   = r;
            valid_s[i] = v;
            code_s[i]  = c;
        end
    endtask

    initial begin
        // reset held with a valid code presented
        drive(1'b1, 1'b1, 3'd5);
        step();
        step();
        drive(1'b0, 1'b0, 3'd5);
        step();

        // single code
        drive(1'b0, 1'b1, 3'd3);
        step();
        drive(1'b0, 1'b0, 3'd3);
        repeat (7) step();

        // back-to-back sweep with in_valid held high
        done_cnt0 = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, 3'(c));
            repeat (6) step();
        end
        check_val("sweep_done_count", 32'(done_cnt0), 32'd8);
        drive(1'b0, 1'b0, 3'd0);
        repeat (6) step();

        // code changes while busy must not disturb y
        drive(1'b0, 1'b1, 3'd2);
        step();
        drive(1'b0, 1'b1, 3'd7);
        repeat (10) step();
        drive(1'b0, 1'b0, 3'd7);
        repeat (8) step();

        // reset during the hold of code 6
        drive(1'b0, 1'b1, 3'd6);
        step();
        drive(1'b0, 1'b0, 3'd6);
        step();
        drive(1'b1, 1'b0, 3'd6);
        step();
        drive(1'b0, 1'b0, 3'd6);
        step();
        step();
        repeat (6) step();

        // corner instance: codes 1 then 4 back-to-back
        drive(1'b0, 1'b1, 3'd1);
        step();
        drive(1'b0, 1'b1, 3'd4);
        step();
        step();
        drive(1'b0, 1'b0, 3'd4);
        repeat (6) step();

        // randomized traffic with occasional reset
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/binary_to_octal_driver.md
Name: binary_to_octal_driver

Overview:
- Reverse of the team's 8-line-to-3-bit octal encoder: accepts a 3-bit binary code over a valid/ready handshake and drives the matching one-hot line of an 8-bit output.
- Holds the line for a programmable number of cycles, then inserts a programmable all-zero gap.
- Sits upstream of line-select logic (LED/row strobes, encoder loopback test) that needs timed, glitch-free one-hot pulses.

Parameters:
- N, 3, binary code width; output width is 2**N (8 at default).
- HOLD, 4, cycles the one-hot line stays asserted per accepted code; legal range >= 1.
- GAP, 1, cycles of all-zero output after each hold, before the next code can be accepted; legal range >= 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a code on in_code.
- in_code  input  N  binary code to decode.
- in_ready  output  1  block can accept a code this cycle.
- y  output  2**N  registered one-hot output.
- busy  output  1  high in the DRIVE and GAP states.
- done  output  1  single-cycle pulse on the last hold cycle.

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - state=IDLE, y=0, busy=0, done=0, counter=0, latched code discarded.
  - in_ready is high in the first cycle after reset.
  - Reset mid-DRIVE or mid-GAP aborts the sequence. y returns to 0 at that edge and no done pulse is produced.
- States: IDLE, DRIVE, GAP. The counter is clog2(max(HOLD,GAP,1)+1) bits wide.
- IDLE:
  - in_ready=1 (decoded from state, no combinational path from in_valid), y=0, busy=0.
  - Acceptance occurs at an edge where in_valid & in_ready are both high.
  - On acceptance: latch in_code, set y = 1<<in_code, counter=HOLD-1, go to DRIVE.
- DRIVE:
  - in_ready=0, busy=1, y holds the one-hot value (exactly one bit set).
  - The counter decrements each cycle.
  - done=1 in the cycle where counter==0 (the HOLD-th cycle with y high).
  - At the edge ending that cycle:
    - GAP>0: y=0, counter=GAP-1, go to GAP.
    - GAP=0: y=0, go to IDLE.
- GAP:
  - y=0, busy=1, in_ready=0, counter decrements.
  - At the edge where counter==0, go to IDLE.
- Timing, with acceptance at the edge ending cycle 0:
  - y is high in cycles 1..HOLD.
  - done is high in cycle HOLD.
  - y is zero in cycles HOLD+1..HOLD+GAP.
  - in_ready rises in cycle HOLD+GAP+1.
  - Minimum accept-to-accept spacing is HOLD+GAP+1 cycles.
- Handshake rules:
  - in_valid while in_ready=0 is ignored and the source must hold it.
  - in_code changes while busy have no effect on y.
- Width rules:
  - Every N-bit code is legal, so no error output exists.
  - y never has more than one bit set.
  - y never changes value except at the start and end of a hold (no glitch between consecutive codes, because the GAP or IDLE cycle intervenes).
- Outputs y, done and busy are registered or decoded from registered state only.

Test Plan (defaults N=3, HOLD=4, GAP=1):
- Reset: rst=1 for 2 cycles with in_valid=1, in_code=5 -> y=0, busy=0, done=0 throughout; in_ready=1 in the first cycle after rst falls.
- Single code:
  - Stimulus: in_code=3 accepted at edge 0.
  - Response: y=8'b00001000 in cycles 1-4, done only in cycle 4, y=0 in cycle 5, in_ready=1 in cycle 6.
- Full sweep: back-to-back codes 0..7 with in_valid held high -> y walks 00000001 through 10000000, each held 4 cycles, each followed by 1 zero cycle; accepts exactly 6 cycles apart, 8 done pulses total.
- Busy-time stimulus ignored: in_code=2 accepted, then in_code=7 with in_valid=1 during DRIVE -> y stays 00000100 for 4 cycles; code 7 is accepted only when in_ready returns.
- Reset mid-operation: rst asserted in cycle 2 of the hold for code 6 -> y=0 from the next edge, no done pulse, in_ready=1 the cycle after rst deasserts.
- Parameter corner: HOLD=1, GAP=0, codes 1 and 4 back-to-back -> y=00000010 for one cycle, then 0 for one cycle, then 00010000 for one cycle; done high with each one-hot cycle.
